// File: rtl/stream_conv2d_pkg.sv
// Shared constants and sizing helpers for the streaming 2-D convolution block.
package stream_conv2d_pkg;

  localparam int COORD_W = 10;
  localparam int LATENCY = 3;

  // Wide enough that a full window of max pixels times extreme coefficients never wraps.
  function automatic int acc_width(input int pix_w, input int coef_w, input int krnl_sz);
    return pix_w + coef_w + $clog2(krnl_sz * krnl_sz) + 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-line delay: dout presents the pixel written DEPTH enabled beats earlier.
module conv_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 320
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_reg;
  logic [AW-1:0]    ptr_reg;
  logic [AW-1:0]    ptr_next;

  always_comb begin
    ptr_next = (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (en) begin
      ptr_reg <= ptr_next;
    end
  end

  // Prefetch the slot the next beat will overwrite, so the registered read lines up.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_reg] <= din;
      dout_reg     <= mem[ptr_next];
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/stream_conv2d.sv
// Streaming KxK convolution: line buffers feed a window, then multiply-accumulate and saturate.
module stream_conv2d
  import stream_conv2d_pkg::*;
#(
  parameter int KRNL_SZ = 5,
  parameter int IMG_W   = 320,
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT   = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PIX_W-1:0]                    in_val,
  input  logic [COORD_W-1:0]                  in_x,
  input  logic [COORD_W-1:0]                  in_y,
  input  logic                                is_in_val,
  input  logic [KRNL_SZ*KRNL_SZ*COEF_W-1:0]   kernel,
  output logic [PIX_W-1:0]                    out_val,
  output logic [COORD_W-1:0]                  out_x,
  output logic [COORD_W-1:0]                  out_y,
  output logic                                is_out_val
);

  localparam int R       = (KRNL_SZ - 1) / 2;
  localparam int NTAP    = KRNL_SZ * KRNL_SZ;
  localparam int ACC_W   = acc_width(PIX_W, COEF_W, KRNL_SZ);
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  logic [PIX_W-1:0]         lb_out  [KRNL_SZ-1];
  logic [PIX_W-1:0]         col_in  [KRNL_SZ];
  logic [PIX_W-1:0]         win_reg [KRNL_SZ][KRNL_SZ];
  logic signed [COEF_W-1:0] coef    [KRNL_SZ][KRNL_SZ];

  logic                     qualify;
  logic                     s1_valid_reg, s2_valid_reg;
  logic [COORD_W-1:0]       s1_x_reg, s1_y_reg, s2_x_reg, s2_y_reg;
  logic signed [ACC_W-1:0]  sum_next, s2_sum_reg, shifted;
  logic [PIX_W-1:0]         sat_val;

  // Column entering the window: row KRNL_SZ-1 is the live pixel, lower rows come from older lines.
  assign col_in[KRNL_SZ-1] = in_val;

  generate
    for (genvar gi = 0; gi < KRNL_SZ - 1; gi++) begin : g_lines
      logic [PIX_W-1:0] lb_in;
      if (gi == 0) begin : g_first
        assign lb_in = in_val;
      end else begin : g_chain
        assign lb_in = lb_out[gi-1];
      end
      conv_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_line (
        .clk   (clk),
        .reset (reset),
        .en    (is_in_val),
        .din   (lb_in),
        .dout  (lb_out[gi])
      );
      assign col_in[KRNL_SZ-2-gi] = lb_out[gi];
    end

    for (genvar gi = 0; gi < KRNL_SZ; gi++) begin : g_coef_row
      for (genvar gj = 0; gj < KRNL_SZ; gj++) begin : g_coef_col
        assign coef[gi][gj] = kernel[(NTAP-1-(gi*KRNL_SZ+gj))*COEF_W +: COEF_W];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (is_in_val) begin
      for (int r = 0; r < KRNL_SZ; r++) begin
        for (int c = 0; c < KRNL_SZ - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][KRNL_SZ-1] <= col_in[r];
      end
    end
  end

  // Border beats never qualify, which also masks stale lines from a previous frame.
  assign qualify = (in_x >= COORD_W'(2 * R)) && (in_y >= COORD_W'(2 * R));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= is_in_val && qualify;
    end
    if (is_in_val) begin
      s1_x_reg <= in_x - COORD_W'(R);
      s1_y_reg <= in_y - COORD_W'(R);
    end
  end

  always_comb begin
    sum_next = '0;
    for (int r = 0; r < KRNL_SZ; r++) begin
      for (int c = 0; c < KRNL_SZ; c++) begin
        sum_next = sum_next + $signed(ACC_W'(win_reg[r][c])) * ACC_W'(coef[r][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
    end
    s2_sum_reg <= sum_next;
    s2_x_reg   <= s1_x_reg;
    s2_y_reg   <= s1_y_reg;
  end

  always_comb begin
    sat_val = '0;
    shifted = s2_sum_reg >>> SHIFT;
    if (shifted < 0) begin
      sat_val = '0;
    end else if (shifted > ACC_W'(PIX_MAX)) begin
      sat_val = PIX_W'(PIX_MAX);
    end else begin
      sat_val = shifted[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_out_val <= 1'b0;
      out_val    <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      is_out_val <= s2_valid_reg;
      out_val    <= s2_valid_reg ? sat_val : '0;
      out_x      <= s2_x_reg;
      out_y      <= s2_y_reg;
    end
  end

endmodule
